// File: rtl/uart_tx_arbiter.sv
// Four-way round-robin arbiter that feeds bytes one frame at a time to a UART
// transmitter, spacing start pulses by a full frame plus a guard interval.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for i_enable and a pending request; grant captures a byte
// ISSUE | one-cycle start pulse to the transmitter, frame timer cleared
// WAIT  | timing out one frame (also the post-reset holdoff)
module uart_tx_arbiter #(
   parameter int CLKS_PER_BIT = 5208,
   parameter int GUARD_CLKS   = 2
) (
   input  logic        clock,
   input  logic        i_reset_n,
   input  logic        i_enable,
   input  logic [3:0]  i_req,
   input  logic [31:0] i_data,
   output logic [3:0]  o_ack,
   output logic        o_data_avail,
   output logic [7:0]  o_data_byte,
   output logic        o_busy,
   output logic [1:0]  o_grant_id
);

   localparam int FRAME_CLKS = 10*CLKS_PER_BIT + GUARD_CLKS;
   localparam int CNT_W      = $clog2(FRAME_CLKS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CLKS-1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [3:0]       ack_nxt;
   logic             avail_nxt;
   logic [7:0]       byte_nxt;
   logic             busy_nxt;
   logic [1:0]       gid_nxt;
   logic             rr_found;
   logic [1:0]       rr_sel;
   logic             grant_go;

   // Search starts one past the last winner; offset 4 wraps back to the last winner itself.
   always_comb begin
      rr_found = 1'b0;
      rr_sel   = o_grant_id;
      for (int i = 1; i <= 4; i++) begin
         if (!rr_found && i_req[o_grant_id + 2'(i)]) begin
            rr_found = 1'b1;
            rr_sel   = o_grant_id + 2'(i);
         end
      end
   end

   assign grant_go = i_enable && rr_found;

   always_ff @(posedge clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= S_WAIT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (grant_go) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT:  if (cnt == CNT_LAST) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      ack_nxt   = '0;
      avail_nxt = 1'b0;
      byte_nxt  = o_data_byte;
      gid_nxt   = o_grant_id;
      cnt_nxt   = cnt;
      busy_nxt  = (state_nxt != S_IDLE);
      case (state)
         S_IDLE: begin
            if (grant_go) begin
               ack_nxt[rr_sel] = 1'b1;
               byte_nxt        = i_data[{rr_sel, 3'b000} +: 8];
               gid_nxt         = rr_sel;
            end
         end
         S_ISSUE: begin
            avail_nxt = 1'b1;
            cnt_nxt   = '0;
         end
         S_WAIT: begin
            // Hold at the terminal count so the timer never wraps.
            if (cnt != CNT_LAST) cnt_nxt = cnt + CNT_W'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt          <= '0;
         o_ack        <= '0;
         o_data_avail <= 1'b0;
         o_data_byte  <= '0;
         o_busy       <= 1'b1;
         o_grant_id   <= 2'd3;
      end else begin
         cnt          <= cnt_nxt;
         o_ack        <= ack_nxt;
         o_data_avail <= avail_nxt;
         o_data_byte  <= byte_nxt;
         o_busy       <= busy_nxt;
         o_grant_id   <= gid_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small UART transmitter/receiver
// pair on the outputs to confirm the bytes that reach the serial line.
module tb_uart_tx_arbiter;

   logic        clock = 1'b0;
   logic        i_reset_n;
   logic        i_enable;
   logic [3:0]  i_req;
   logic [31:0] i_data;
   logic [3:0]  o_ack;
   logic        o_data_avail;
   logic [7:0]  o_data_byte;
   logic        o_busy;
   logic [1:0]  o_grant_id;

   int checks = 0;
   int errors = 0;

   uart_tx_arbiter #(.CLKS_PER_BIT(4), .GUARD_CLKS(2)) dut (
      .clock        (clock),
      .i_reset_n    (i_reset_n),
      .i_enable     (i_enable),
      .i_req        (i_req),
      .i_data       (i_data),
      .o_ack        (o_ack),
      .o_data_avail (o_data_avail),
      .o_data_byte  (o_data_byte),
      .o_busy       (o_busy),
      .o_grant_id   (o_grant_id)
   );

   always #5 clock = ~clock;

   // Transmitter: 4 clocks per bit, start + 8 data (LSB first) + stop.
   logic       tx_busy = 1'b0;
   logic [9:0] tx_sh = '1;
   int         tx_clk = 0;
   int         tx_bits = 0;
   int         collisions = 0;
   logic       txd;
   assign txd = tx_busy ? tx_sh[0] : 1'b1;

   always @(posedge clock) begin
      if (tx_busy) begin
         if (o_data_avail) collisions <= collisions + 1;
         if (tx_clk == 3) begin
            tx_clk  <= 0;
            tx_sh   <= {1'b1, tx_sh[9:1]};
            tx_bits <= tx_bits + 1;
            if (tx_bits == 9) tx_busy <= 1'b0;
         end else begin
            tx_clk <= tx_clk + 1;
         end
      end else if (o_data_avail) begin
         tx_sh   <= {1'b1, o_data_byte, 1'b0};
         tx_busy <= 1'b1;
         tx_clk  <= 0;
         tx_bits <= 0;
      end
   end

   // Receiver samples each bit near its centre.
   logic       rx_act = 1'b0;
   int         rx_j = 0;
   logic [7:0] rx_sh = '0;
   int         stop_err = 0;
   logic [7:0] rx_q[$];

   always @(posedge clock) begin
      if (!rx_act) begin
         if (txd == 1'b0) begin
            rx_act <= 1'b1;
            rx_j   <= 1;
         end
      end else begin
         rx_j <= rx_j + 1;
         if ((rx_j + 1) >= 7 && (rx_j + 1) <= 35 && ((rx_j + 1 - 3) % 4) == 0)
            rx_sh <= {txd, rx_sh[7:1]};
         if ((rx_j + 1) == 39) begin
            if (txd !== 1'b1) stop_err <= stop_err + 1;
            rx_q.push_back(rx_sh);
            rx_act <= 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called just after the ISSUE edge; WAIT lasts 42 edges.
   task automatic wait_idle_exact(input string tag);
      int av = 0;
      int lo = 0;
      repeat (41) begin
         @(negedge clock);
         if (o_data_avail) av++;
         if (!o_busy) lo++;
      end
      check({tag, " avail_in_wait"}, av, 0);
      check({tag, " busy_low_in_wait"}, lo, 0);
      @(negedge clock);
      check({tag, " busy_end"}, o_busy, 0);
   endtask

   task automatic one_frame(input string tag, input logic [3:0] req, input logic [31:0] data,
                            input logic [3:0] exp_ack, input logic [1:0] exp_gid,
                            input logic [7:0] exp_byte);
      i_req  = req;
      i_data = data;
      @(negedge clock);
      check({tag, " ack"}, o_ack, exp_ack);
      check({tag, " gid"}, o_grant_id, exp_gid);
      check({tag, " byte"}, o_data_byte, exp_byte);
      i_req = '0;
      @(negedge clock);
      check({tag, " avail"}, o_data_avail, 1);
      check({tag, " ack_clear"}, o_ack, 0);
      wait_idle_exact(tag);
   endtask

   // Called at a negedge with reset low; releases reset and checks the holdoff.
   task automatic holdoff_check(input string tag, input logic [3:0] req, input logic [31:0] data,
                                input logic [3:0] exp_ack, input logic [1:0] exp_gid,
                                input logic [7:0] exp_byte);
      int acks = 0;
      int av = 0;
      i_req     = req;
      i_data    = data;
      i_reset_n = 1'b1;
      repeat (42) begin
         @(negedge clock);
         if (o_ack != 0) acks++;
         if (o_data_avail) av++;
      end
      check({tag, " ack_in_holdoff"}, acks, 0);
      check({tag, " avail_in_holdoff"}, av, 0);
      @(negedge clock);
      check({tag, " ack"}, o_ack, exp_ack);
      check({tag, " gid"}, o_grant_id, exp_gid);
      check({tag, " byte"}, o_data_byte, exp_byte);
      i_req = '0;
      @(negedge clock);
      check({tag, " avail"}, o_data_avail, 1);
      check({tag, " byte_held"}, o_data_byte, exp_byte);
      wait_idle_exact(tag);
   endtask

   initial begin
      int         n;
      int         acks;
      int         bz;
      int         av;
      int         overlap;
      int         bad_onehot;
      int         cyc;
      int         av_cyc[$];
      logic [9:0] gseq;
      logic [39:0] bseq;
      logic [31:0] rxw;

      i_reset_n = 1'b0;
      i_enable  = 1'b1;
      i_req     = '0;
      i_data    = '0;

      // Reset values
      @(negedge clock);
      check("rst busy", o_busy, 1);
      check("rst ack", o_ack, 0);
      check("rst avail", o_data_avail, 0);
      check("rst byte", o_data_byte, 0);
      check("rst gid", o_grant_id, 3);
      @(negedge clock);

      // Holdoff after reset with requester 0 waiting
      holdoff_check("holdoff0", 4'b0001, 32'h0000_003C, 4'b0001, 2'd0, 8'h3C);

      // Single request on requester 2
      one_frame("single2", 4'b0100, 32'h00A5_0000, 4'b0100, 2'd2, 8'hA5);

      // Enable gating, then an enable fall mid-frame must not abort
      i_enable = 1'b0;
      i_req    = 4'b0010;
      i_data   = 32'h0000_5A00;
      acks = 0;
      bz   = 0;
      repeat (20) begin
         @(negedge clock);
         if (o_ack != 0) acks++;
         if (o_busy) bz++;
      end
      check("en_low ack", acks, 0);
      check("en_low busy", bz, 0);
      i_enable = 1'b1;
      @(negedge clock);
      check("en_high ack", o_ack, 4'b0010);
      check("en_high gid", o_grant_id, 2'd1);
      check("en_high byte", o_data_byte, 8'h5A);
      i_enable = 1'b0;
      i_req    = '0;
      @(negedge clock);
      check("en_fall avail", o_data_avail, 1);
      wait_idle_exact("en_fall");
      i_enable = 1'b1;

      // Reset the cycle after an ack drops the start pulse
      i_req  = 4'b1000;
      i_data = 32'h7700_0000;
      @(negedge clock);
      check("rst_mid ack", o_ack, 4'b1000);
      check("rst_mid gid", o_grant_id, 2'd3);
      i_reset_n = 1'b0;
      #1;
      check("rst_async ack", o_ack, 0);
      check("rst_async avail", o_data_avail, 0);
      check("rst_async busy", o_busy, 1);
      check("rst_async byte", o_data_byte, 0);
      i_req = '0;
      av = 0;
      repeat (3) begin
         @(negedge clock);
         if (o_data_avail) av++;
      end
      check("rst_mid avail_dropped", av, 0);
      holdoff_check("rst_holdoff", 4'b1000, 32'h7700_0000, 4'b1000, 2'd3, 8'h77);

      // Bytes seen on the serial line so far
      rxw = '0;
      foreach (rx_q[i]) rxw = {rxw[23:0], rx_q[i]};
      check("line count", rx_q.size(), 4);
      check("line bytes", rxw, 32'h3CA5_5A77);
      rx_q.delete();

      // Serial loopback: requesters 0 and 1 held together
      i_req  = 4'b0011;
      i_data = 32'h0000_0F55;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (o_ack == 0 && n < 10);
      check("loop ack0", o_ack, 4'b0001);
      check("loop byte0", o_data_byte, 8'h55);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (o_ack == 0 && n < 60);
      check("loop ack1", o_ack, 4'b0010);
      check("loop byte1", o_data_byte, 8'h0F);
      i_req = '0;
      n = 0;
      while (rx_q.size() < 2 && n < 120) begin
         @(negedge clock);
         n++;
      end
      rxw = '0;
      foreach (rx_q[i]) rxw = {rxw[23:0], rx_q[i]};
      check("loop count", rx_q.size(), 2);
      check("loop bytes", rxw, 32'h0000_550F);
      check("loop collisions", collisions, 0);
      check("loop stop_bits", stop_err, 0);
      n = 0;
      while (o_busy && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("loop idle", o_busy, 0);

      // Park the pointer on requester 3, then hold all four requests
      one_frame("set_gid3", 4'b1000, 32'h9900_0000, 4'b1000, 2'd3, 8'h99);
      i_req      = 4'b1111;
      i_data     = 32'h4433_2211;
      gseq       = '0;
      bseq       = '0;
      overlap    = 0;
      bad_onehot = 0;
      cyc        = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clock);
         cyc++;
         if (o_ack != 0) begin
            gseq = {gseq[7:0], o_grant_id};
            if ($countones(o_ack) != 1) bad_onehot++;
            if (o_data_avail) overlap++;
         end
         if (o_data_avail) begin
            av_cyc.push_back(cyc);
            bseq = {bseq[31:0], o_data_byte};
         end
         if (av_cyc.size() == 5) break;
      end
      i_req = '0;
      check("rr pulses", av_cyc.size(), 5);
      check("rr order", gseq, 10'b00_01_10_11_00);
      check("rr bytes", bseq, 40'h11_2233_4411);
      check("rr onehot", bad_onehot, 0);
      check("rr ack_avail_overlap", overlap, 0);
      if (av_cyc.size() == 5) begin
         for (int i = 1; i < 5; i++)
            check($sformatf("rr spacing%0d", i), av_cyc[i] - av_cyc[i-1], 44);
      end
      n = 0;
      while (o_busy && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("rr idle", o_busy, 0);
      check("final collisions", collisions, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
